// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dmem_arb_pkg
// Brief   : Shared types and constants for the two-port data-memory arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

    localparam int C_DATA_WIDTH = 32;
    localparam int C_ADDR_WIDTH = 7;

    localparam logic C_PORT0 = 1'b0;
    localparam logic C_PORT1 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

endpackage : dmem_arb_pkg
`default_nettype wire

// File: rtl/dmem_arb_if.sv
`default_nettype none
// ============================================================================
// Module  : dmem_arb_if
// Brief   : Requester ports and memory port of the data-memory arbiter.
// Revision: 1.0 - initial release
// ============================================================================
interface dmem_arb_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7
);
    logic                  i_req0;
    logic                  i_req1;
    logic                  i_wr0;
    logic                  i_wr1;
    logic                  i_lock0;
    logic                  i_lock1;
    logic [ADDR_WIDTH-1:0] i_addr0;
    logic [ADDR_WIDTH-1:0] i_addr1;
    logic [DATA_WIDTH-1:0] i_wdata0;
    logic [DATA_WIDTH-1:0] i_wdata1;
    logic                  o_gnt0;
    logic                  o_gnt1;
    logic                  o_rvalid0;
    logic                  o_rvalid1;
    logic [DATA_WIDTH-1:0] o_rdata0;
    logic [DATA_WIDTH-1:0] o_rdata1;
    logic [DATA_WIDTH-1:0] o_mem_addr;
    logic [DATA_WIDTH-1:0] o_mem_wdata;
    logic                  o_mem_wr;
    logic [DATA_WIDTH-1:0] i_mem_rdata;

    // Arbiter side
    modport slave (
        input  i_req0, i_req1, i_wr0, i_wr1, i_lock0, i_lock1,
        input  i_addr0, i_addr1, i_wdata0, i_wdata1, i_mem_rdata,
        output o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_rdata0, o_rdata1,
        output o_mem_addr, o_mem_wdata, o_mem_wr
    );

    // Requesters plus memory side
    modport master (
        output i_req0, i_req1, i_wr0, i_wr1, i_lock0, i_lock1,
        output i_addr0, i_addr1, i_wdata0, i_wdata1, i_mem_rdata,
        input  o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_rdata0, o_rdata1,
        input  o_mem_addr, o_mem_wdata, o_mem_wr
    );
endinterface : dmem_arb_if
`default_nettype wire

// File: rtl/dmem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module  : dmem_arb_pick
// Brief   : Combinational next-owner selection. DMEM_ARB_RR_EN selects
//           round-robin conflict resolution, otherwise port 0 has priority.
// Revision: 1.0 - initial release
// ============================================================================
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  state_t i_state,
    input  logic   i_req0,
    input  logic   i_req1,
    input  logic   i_lock0,
    input  logic   i_lock1,
    input  logic   i_last,   // port served most recently, including this cycle
    output state_t o_next
);

`ifndef DMEM_ARB_RR_EN
    logic w_unused_last;
    assign w_unused_last = i_last;
`endif

    always_comb begin
        o_next = ST_IDLE;
        if (i_state == ST_OWN0 && i_lock0 && i_req0) begin
            o_next = ST_OWN0;
        end else if (i_state == ST_OWN1 && i_lock1 && i_req1) begin
            o_next = ST_OWN1;
        end else if (i_req0 && i_req1) begin
`ifdef DMEM_ARB_RR_EN
            o_next = (i_last == C_PORT1) ? ST_OWN0 : ST_OWN1;
`else
            o_next = ST_OWN0;
`endif
        end else if (i_req0) begin
            o_next = ST_OWN0;
        end else if (i_req1) begin
            o_next = ST_OWN1;
        end
    end

endmodule : dmem_arb_pick
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dmem_arbiter
// Brief   : Two-port arbiter/sequencer for a single-port data memory with
//           registered read return. DMEM_ARB_RR_EN enables round-robin.
// Revision: 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = C_DATA_WIDTH,
    parameter int ADDR_WIDTH = C_ADDR_WIDTH
) (
    input  logic       i_clk,
    input  logic       i_rst,
    dmem_arb_if.slave  bus
);

    state_t                state_q, state_d;
    logic                  last_q, last_d;
    logic                  rvalid0_q, rvalid1_q;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;

    logic                  w_gnt0, w_gnt1;
    logic                  w_rd0, w_rd1;

    assign w_gnt0 = (state_q == ST_OWN0) && bus.i_req0;
    assign w_gnt1 = (state_q == ST_OWN1) && bus.i_req1;
    assign w_rd0  = w_gnt0 && !bus.i_wr0;
    assign w_rd1  = w_gnt1 && !bus.i_wr1;

    // The transfer happening now counts as the last one served, so streaming
    // requesters alternate without a repeated grant.
    assign last_d = w_gnt1 ? C_PORT1 : (w_gnt0 ? C_PORT0 : last_q);

    dmem_arb_pick u_pick (
        .i_state (state_q),
        .i_req0  (bus.i_req0),
        .i_req1  (bus.i_req1),
        .i_lock0 (bus.i_lock0),
        .i_lock1 (bus.i_lock1),
        .i_last  (last_d),
        .o_next  (state_d)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            last_q  <= C_PORT1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            rvalid0_q <= w_rd0;
            rvalid1_q <= w_rd1;
            if (w_rd0) rdata0_q <= bus.i_mem_rdata;
            if (w_rd1) rdata1_q <= bus.i_mem_rdata;
        end
    end

    always_comb begin
        bus.o_gnt0      = w_gnt0;
        bus.o_gnt1      = w_gnt1;
        bus.o_rvalid0   = rvalid0_q;
        bus.o_rvalid1   = rvalid1_q;
        bus.o_rdata0    = rdata0_q;
        bus.o_rdata1    = rdata1_q;
        bus.o_mem_addr  = '0;
        bus.o_mem_wdata = '0;
        bus.o_mem_wr    = 1'b0;
        if (w_gnt0) begin
            bus.o_mem_addr  = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, bus.i_addr0};
            bus.o_mem_wdata = bus.i_wdata0;
            bus.o_mem_wr    = bus.i_wr0;
        end else if (w_gnt1) begin
            bus.o_mem_addr  = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, bus.i_addr1};
            bus.o_mem_wdata = bus.i_wdata1;
            bus.o_mem_wr    = bus.i_wr1;
        end
    end

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_arbiter
// Brief   : Scoreboard bench for dmem_arbiter with a transaction-level model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    typedef struct {
        logic        wr;
        logic        lock;
        logic [6:0]  addr;
        logic [31:0] wdata;
    } txn_t;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_init = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    txn_t        txq [2][$];
    exp_t        expq[2][$];
    int          glog[$];
    logic [31:0] last_rd[2];
    logic [31:0] ref_mem[128];
    logic [31:0] mem[128];
    int          m_owner = -1;
    int          m_last  = 1;

    dmem_arb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(7)) bus ();

    dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(7)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_val(int i);
        return 32'hA5A5_0000 ^ (i * 32'h0101_0101);
    endfunction

    assign bus.i_mem_rdata = mem[bus.o_mem_addr[6:0]];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 128; i++) mem[i] <= init_val(i);
        end else if (bus.o_mem_wr) begin
            mem[bus.o_mem_addr[6:0]] <= bus.o_mem_wdata;
        end
    end

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic drive();
        bus.i_req0 = (txq[0].size() > 0);
        bus.i_req1 = (txq[1].size() > 0);
        {bus.i_wr0, bus.i_lock0, bus.i_addr0, bus.i_wdata0} = '0;
        {bus.i_wr1, bus.i_lock1, bus.i_addr1, bus.i_wdata1} = '0;
        if (bus.i_req0) begin
            bus.i_wr0 = txq[0][0].wr;       bus.i_lock0  = txq[0][0].lock;
            bus.i_addr0 = txq[0][0].addr;   bus.i_wdata0 = txq[0][0].wdata;
        end
        if (bus.i_req1) begin
            bus.i_wr1 = txq[1][0].wr;       bus.i_lock1  = txq[1][0].lock;
            bus.i_addr1 = txq[1][0].addr;   bus.i_wdata1 = txq[1][0].wdata;
        end
    endtask

    // Ownership model: who may transfer now, and who owns next cycle.
    task automatic model_check();
        bit   r[2], l[2];
        int   p, served;
        txn_t t;
        r[0] = bus.i_req0;  r[1] = bus.i_req1;
        l[0] = bus.i_lock0; l[1] = bus.i_lock1;
        p = -1;
        if (m_owner >= 0 && r[m_owner]) p = m_owner;
        check("gnt", {62'd0, bus.o_gnt1, bus.o_gnt0}, {62'd0, p == 1, p == 0});
        if (p >= 0) begin
            t = txq[p][0];
            check("mem_wr", {63'd0, bus.o_mem_wr}, {63'd0, t.wr});
            check("mem_addr", {32'd0, bus.o_mem_addr}, {57'd0, t.addr});
            check("mem_wdata", {32'd0, bus.o_mem_wdata}, {32'd0, t.wdata});
            if (t.wr) ref_mem[t.addr] = t.wdata;
            else      expq[p].push_back('{ref_mem[t.addr], cyc + 1});
            glog.push_back(p);
            served = p;
        end else begin
            check("idle_bus", {bus.o_mem_wr, bus.o_mem_addr, 31'd0},
                  {1'b0, 32'd0, 31'd0});
            check("idle_wdata", {32'd0, bus.o_mem_wdata}, 64'd0);
            served = m_last;
        end
        if (m_owner >= 0 && l[m_owner] && r[m_owner]) begin
            // locked burst continues
        end else if (r[0] && r[1]) begin
`ifdef DMEM_ARB_RR_EN
            m_owner = 1 - served;
`else
            m_owner = 0;
`endif
        end else if (r[0]) m_owner = 0;
        else if (r[1])     m_owner = 1;
        else               m_owner = -1;
        m_last = served;
    endtask

    task automatic step();
        @(posedge clk); #1;
        drive();
        @(negedge clk);
        model_check();
        if (bus.o_gnt0 && txq[0].size() > 0) void'(txq[0].pop_front());
        if (bus.o_gnt1 && txq[1].size() > 0) void'(txq[1].pop_front());
    endtask

    task automatic drain();
        int n = 0;
        while ((txq[0].size() + txq[1].size() + expq[0].size() + expq[1].size()) > 0
               && n < 500) begin
            step();
            n++;
        end
        if (n >= 500) begin
            checks++; errors++;
            $display("FAIL drain_timeout actual=pending required=empty");
            txq[0].delete(); txq[1].delete();
        end
        step(); step();
    endtask

    task automatic do_reset(bit mid);
        @(posedge clk); #1;
        drive();
        #1;
        if (mid) begin
            check("pre_gnt0", {63'd0, bus.o_gnt0}, 64'd1);
            check("pre_rvalid0", {63'd0, bus.o_rvalid0}, 64'd1);
        end
        rst = 1'b1;
        #1;
        check("rst_gnt", {62'd0, bus.o_gnt1, bus.o_gnt0}, 64'd0);
        check("rst_mem_wr", {63'd0, bus.o_mem_wr}, 64'd0);
        check("rst_rvalid", {62'd0, bus.o_rvalid1, bus.o_rvalid0}, 64'd0);
        check("rst_rdata0", {32'd0, bus.o_rdata0}, 64'd0);
        txq[0].delete(); txq[1].delete();
        expq[0].delete(); expq[1].delete();
        last_rd[0] = '0; last_rd[1] = '0;
        m_owner = -1; m_last = 1;
        drive();
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic push(int p, logic wr, logic lock, logic [6:0] a, logic [31:0] d);
        txq[p].push_back('{wr, lock, a, d});
    endtask

    task automatic check_glog(string nm, int exp[$]);
        check({nm, "_len"}, 64'(glog.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < glog.size(); i++)
            check($sformatf("%s_%0d", nm, i), 64'(glog[i]), 64'(exp[i]));
    endtask

    // Read-return monitor: rvalid exactly one cycle after the read grant.
    initial begin
        forever begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                bit   ev;
                logic rv;
                logic [31:0] rd;
                rv = (p == 0) ? bus.o_rvalid0 : bus.o_rvalid1;
                rd = (p == 0) ? bus.o_rdata0  : bus.o_rdata1;
                ev = (expq[p].size() > 0) && (expq[p][0].cyc == cyc);
                check($sformatf("rvalid%0d", p), {63'd0, rv}, {63'd0, ev});
                if (ev) last_rd[p] = expq[p].pop_front().data;
                check($sformatf("rdata%0d", p), {32'd0, rd}, {32'd0, last_rd[p]});
            end
        end
    end

    initial begin
        int e3[$], e4[$], e5[$], e6[$];
        for (int i = 0; i < 128; i++) ref_mem[i] = init_val(i);
        last_rd[0] = '0; last_rd[1] = '0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        mem_init = 1'b0;
        check("reset_outputs",
              {bus.o_gnt0, bus.o_gnt1, bus.o_mem_wr, bus.o_rvalid0, bus.o_rvalid1,
               27'd0, bus.o_mem_addr | bus.o_mem_wdata | bus.o_rdata0 | bus.o_rdata1},
              64'd0);
        rst = 1'b0;

        // Reset in the middle of a read stream
        for (int i = 0; i < 4; i++) push(0, 1'b0, 1'b1, 7'(20 + i), $urandom);
        step(); step();
        do_reset(1'b1);

        // Write then read back through port 0
        push(0, 1'b1, 1'b0, 7'd5, 32'hDEAD_BEEF);
        push(0, 1'b0, 1'b0, 7'd5, $urandom);
        drain();
        check("rd_after_wr", {32'd0, last_rd[0]}, {32'd0, 32'hDEAD_BEEF});

        // Simultaneous requests from IDLE, port 0 streaming
        do_reset(1'b0);
        glog.delete();
        for (int i = 0; i < 4; i++) push(0, 1'b0, 1'b0, 7'(30 + i), $urandom);
        push(1, 1'b0, 1'b0, 7'd40, $urandom);
        drain();
`ifdef DMEM_ARB_RR_EN
        e3 = '{0, 1, 0, 0, 0};
`else
        e3 = '{0, 0, 0, 0, 1};
`endif
        check_glog("order3", e3);

        // Both ports streaming
        do_reset(1'b0);
        glog.delete();
        for (int i = 0; i < 4; i++) begin
            push(0, 1'b0, 1'b0, 7'(50 + i), $urandom);
            push(1, 1'b0, 1'b0, 7'(60 + i), $urandom);
        end
        drain();
`ifdef DMEM_ARB_RR_EN
        e4 = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
        e4 = '{0, 0, 0, 0, 1, 1, 1, 1};
`endif
        check_glog("order4", e4);

        // Port 1 locked write burst while port 0 waits
        glog.delete();
        for (int i = 0; i < 3; i++) push(1, 1'b1, 1'b1, 7'(10 + i), 32'hB000_0000 + i);
        step();
        push(0, 1'b0, 1'b0, 7'd11, $urandom);
        push(0, 1'b0, 1'b0, 7'd12, $urandom);
        drain();
        e5 = '{1, 1, 1, 0, 0};
        check_glog("order5", e5);
        for (int i = 0; i < 3; i++)
            check($sformatf("burst_mem_%0d", i), {32'd0, mem[10 + i]}, {32'd0, 32'hB000_0000 + i});

        // Read and write to the same word at the same time
        glog.delete();
        push(0, 1'b0, 1'b0, 7'd7, $urandom);
        push(1, 1'b1, 1'b0, 7'd7, 32'h7777_0007);
        drain();
`ifdef DMEM_ARB_RR_EN
        e6 = '{1, 0};
        check("same_addr_rd", {32'd0, last_rd[0]}, {32'd0, 32'h7777_0007});
`else
        e6 = '{0, 1};
        check("same_addr_rd", {32'd0, last_rd[0]}, {32'd0, init_val(7)});
`endif
        check_glog("order6", e6);

        // Randomized traffic with one reset in the middle
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < 2; p++) begin
                if ($urandom_range(2) == 0 && txq[p].size() < 4)
                    push(p, 1'($urandom_range(1)), 1'($urandom_range(3) == 0),
                         7'($urandom_range(15)), $urandom);
            end
            if (n == 200) do_reset(1'b0);
            else          step();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_dmem_arbiter
`default_nettype wire
